// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle CPU main control, Moore FSM over fetch/decode/execute/memory/writeback
module mc_control_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       Illegal,
  output logic [3:0] State
);
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_REXEC, S_RWB, S_BEQ, S_JUMP, S_ADDIEX, S_ADDIWB
  } state_t;
  state_t state, next;
  logic ill_q, ill_d;
  assign State = state;
  // decode falling back to fetch from S1 means the opcode was not recognised
  assign ill_d = (state == S_DECODE) && (next == S_FETCH);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      ill_q <= 1'b0;
    end else begin
      state <= next;
      ill_q <= ill_d;
    end
  end
  always_comb begin
    next = S_FETCH;
    {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource} = '0;
    Illegal = ill_q;
    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        ALUSrcB = 2'b01;
        PCWrite = 1'b1;
        next = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        next = (Op == OP_LW || Op == OP_SW) ? S_MEMADR :
               (Op == OP_RTYPE) ? S_REXEC :
               (Op == OP_BEQ) ? S_BEQ :
               (Op == OP_J) ? S_JUMP :
               (Op == OP_ADDI) ? S_ADDIEX : S_FETCH;
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        next = (Op == OP_LW) ? S_MEMRD : (Op == OP_SW) ? S_MEMWR : S_FETCH;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD = 1'b1;
        next = S_MEMWB;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD = 1'b1;
      end
      S_REXEC: begin
        ALUSrcA = 1'b1;
        ALUOp = 2'b10;
        next = S_RWB;
      end
      S_RWB: begin
        RegDst = 1'b1;
        RegWrite = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = 1'b1;
        ALUOp = 2'b01;
        PCWriteCond = 1'b1;
        PCSource = 2'b01;
      end
      S_JUMP: begin
        PCWrite = 1'b1;
        PCSource = 2'b10;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        next = S_ADDIWB;
      end
      S_ADDIWB: RegWrite = 1'b1;
      default: next = S_FETCH;
    endcase
    if (reset) begin
      {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource} = '0;
      Illegal = 1'b0;
    end
  end
endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: scoreboard bench, expected per-cycle state/outputs queued per instruction
module tb_mc_control_fsm;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [5:0] Op = 6'd0;
  logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, Illegal;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] State;
  int checks = 0;
  int failures = 0;
  logic pend_ill = 1'b0;
  typedef struct {
    logic [3:0] st;
    logic ill;
  } exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  mc_control_fsm dut (
    .clk(clk), .reset(reset), .Op(Op),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .Illegal(Illegal), .State(State)
  );
  logic [15:0] obs;
  assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};
  // bit order: pcw pcwc iord mr mw irw m2r rdst rw srca | srcb aluop pcsrc
  function automatic logic [15:0] exp_o(input logic [3:0] s);
    case (s)
      4'd0:  return 16'b1001010000_010000;
      4'd1:  return 16'b0000000000_110000;
      4'd2:  return 16'b0000000001_100000;
      4'd3:  return 16'b0011000000_000000;
      4'd4:  return 16'b0000001010_000000;
      4'd5:  return 16'b0010100000_000000;
      4'd6:  return 16'b0000000001_001000;
      4'd7:  return 16'b0000000110_000000;
      4'd8:  return 16'b0100000001_000101;
      4'd9:  return 16'b1000000000_000010;
      4'd10: return 16'b0000000001_100000;
      4'd11: return 16'b0000000010_000000;
      default: return 16'd0;
    endcase
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic push(input logic [3:0] s);
    exp_t e;
    e.st = s;
    e.ill = pend_ill;
    pend_ill = 1'b0;
    q.push_back(e);
  endtask
  task automatic queue_instr(input logic [5:0] op);
    push(4'd0);
    push(4'd1);
    case (op)
      6'b100011: begin push(4'd2); push(4'd3); push(4'd4); end
      6'b101011: begin push(4'd2); push(4'd5); end
      6'b000000: begin push(4'd6); push(4'd7); end
      6'b000100: push(4'd8);
      6'b000010: push(4'd9);
      6'b001000: begin push(4'd10); push(4'd11); end
      default: pend_ill = 1'b1;
    endcase
  endtask
  task automatic check_cycle(input exp_t e);
    chk("state", 32'(State), 32'(e.st));
    chk($sformatf("outs_s%0d", e.st), 32'(obs), 32'(exp_o(e.st)));
    chk("illegal", 32'(Illegal), 32'(e.ill));
    chk("inv_mem", 32'(MemRead & MemWrite), 32'd0);
    chk("inv_rw_ir", 32'(RegWrite & IRWrite), 32'd0);
    chk("inv_pc", 32'(PCWrite & PCWriteCond), 32'd0);
  endtask
  task automatic drain();
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      check_cycle(e);
      @(negedge clk);
      #1;
    end
  endtask
  task automatic run(input logic [5:0] op);
    Op = op;
    #1;
    queue_instr(op);
    drain();
  endtask
  logic [5:0] ops[6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010, 6'b001000};
  initial begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("rst_outs", 32'(obs), 32'd0);
      chk("rst_ill", 32'(Illegal), 32'd0);
      chk("rst_state", 32'(State), 32'd0);
    end
    reset = 1'b0;
    run(6'b100011);
    run(6'b000000);
    run(6'b001000);
    run(6'b101011);
    run(6'b000100);
    run(6'b000010);
    run(6'b111111);
    run(6'b000000);
    Op = 6'b100011;
    #1;
    queue_instr(Op);
    for (int i = 0; i < 3; i++) begin
      e = q.pop_front();
      check_cycle(e);
      @(negedge clk);
      #1;
    end
    e = q.pop_front();
    check_cycle(e);
    q.delete();
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("midrst_state", 32'(State), 32'd0);
    chk("midrst_rw", 32'(RegWrite), 32'd0);
    chk("midrst_outs", 32'(obs), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 25; i++)
      run(($urandom_range(0, 4) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)]);
    run(6'b000010);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
